write_buffer: RTL and testbench

WRITE_BUFFER -- requirements
Module: write_buffer

---
 rtl/wb_pkg.sv | 29 ++
 rtl/wb_cam.sv | 28 ++
 rtl/write_buffer.sv | 152 +++++++++++++++
 tb/tb_write_buffer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the write-through store buffer.
// Holds the data widths, default geometry, the entry struct and the FSM state encoding.
package wb_pkg;

  localparam int unsigned ADDR_W       = 16;
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned CNT_W        = 4;
  localparam int unsigned WB_DEPTH     = 4;
  localparam int unsigned WB_BLK_OFF_W = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StFlush  = 2'd2
  } wb_state_t;

  // Selects the block-number bits of an address, so that the byte offset is ignored.
  function automatic logic [ADDR_W-1:0] blk_mask(input int unsigned off_w);
    logic [ADDR_W-1:0] one;
    one = ADDR_W'(1);
    return ~((one << off_w) - one);
  endfunction

endpackage

// File: rtl/wb_cam.sv
// Per-entry address comparators for the store buffer.
// blk_match feeds the fill-conflict check; exact_match feeds store coalescing.
module wb_cam
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH     = WB_DEPTH,
  parameter int unsigned BLK_OFF_W = WB_BLK_OFF_W
) (
  input  logic [ADDR_W-1:0] entry_addr [DEPTH],
  input  logic [DEPTH-1:0]  entry_valid,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [ADDR_W-1:0] st_addr,
  output logic [DEPTH-1:0]  blk_match,
  output logic [DEPTH-1:0]  exact_match
);

  localparam logic [ADDR_W-1:0] BlkMask = blk_mask(BLK_OFF_W);

  always_comb begin
    blk_match   = '0;
    exact_match = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      blk_match[i]   = entry_valid[i] & (((entry_addr[i] ^ fill_addr) & BlkMask) == '0);
      exact_match[i] = entry_valid[i] & (entry_addr[i] == st_addr);
    end
  end

endmodule

// File: rtl/write_buffer.sv
// Write-through store buffer: circular FIFO of {addr, data} drained to memory when granted.
// Optional macro WB_COALESCE_EN merges a store into a buffered entry at the same address.
module write_buffer
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH     = WB_DEPTH,
  parameter int unsigned BLK_OFF_W = WB_BLK_OFF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ready,
  input  logic              mem_grant,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [ADDR_W-1:0] fill_addr,
  output logic              fill_conflict,
  input  logic              flush,
  output logic              flush_done,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned      PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);

  wb_entry_t         entries_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q, count_d;
  wb_state_t         state_q, state_d;

  logic [ADDR_W-1:0] entry_addr [DEPTH];
  logic [DEPTH-1:0]  blk_match, exact_match;
  logic              is_empty, is_full, pop, accept, alloc;
  logic              coal_hit;
  logic [PTR_W-1:0]  coal_idx;

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      entry_addr[i] = entries_q[i].addr;
    end
  end

  wb_cam #(
    .DEPTH     (DEPTH),
    .BLK_OFF_W (BLK_OFF_W)
  ) u_cam (
    .entry_addr  (entry_addr),
    .entry_valid (valid_q),
    .fill_addr   (fill_addr),
    .st_addr     (st_addr),
    .blk_match   (blk_match),
    .exact_match (exact_match)
  );

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FullCnt);
  assign pop      = ~is_empty & mem_grant;

`ifdef WB_COALESCE_EN
  // The head entry leaving this cycle cannot absorb a store; it gets a fresh slot instead.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (exact_match[i] && !(pop && (head_q == PTR_W'(i))) && !coal_hit) begin
        coal_hit = 1'b1;
        coal_idx = PTR_W'(i);
      end
    end
  end

  assign st_ready = (state_q != StFlush) & (~is_full | coal_hit);
`else
  logic unused_exact;
  assign unused_exact = ^exact_match;
  assign coal_hit     = 1'b0;
  assign coal_idx     = '0;
  assign st_ready     = (state_q != StFlush) & ~is_full;
`endif

  assign accept  = st_valid & st_ready;
  assign alloc   = accept & ~coal_hit;
  assign count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flush)      state_d = StFlush;
        else if (alloc) state_d = StActive;
      end
      StActive: begin
        if (flush)                state_d = StFlush;
        else if (count_d == '0)   state_d = StIdle;
      end
      StFlush: begin
        if (is_empty) begin
          flush_done = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (pop) begin
        head_q          <= head_q + PtrOne;
        valid_q[head_q] <= 1'b0;
      end
      if (alloc) begin
        tail_q          <= tail_q + PtrOne;
        valid_q[tail_q] <= 1'b1;
      end
    end
  end

  // Payload storage needs no reset: valid_q and count_q gate every use of it.
  always_ff @(posedge clk) begin
    if (alloc) begin
      entries_q[tail_q] <= '{addr: st_addr, data: st_data};
    end else if (accept && coal_hit) begin
      entries_q[coal_idx].data <= st_data;
    end
  end

  assign mem_en        = pop;
  assign mem_wr        = pop;
  assign mem_addr      = pop ? entries_q[head_q].addr : '0;
  assign mem_data      = pop ? entries_q[head_q].data : '0;
  assign fill_conflict = |blk_match;
  assign empty         = is_empty;
  assign count         = count_q;

endmodule

// File: tb/tb_write_buffer.sv
// Directed self-checking bench for write_buffer (DEPTH=4, 16-byte blocks).
module tb_write_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic [15:0] st_addr;
  logic [15:0] st_data;
  logic        st_ready;
  logic        mem_grant;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic [15:0] fill_addr;
  logic        fill_conflict;
  logic        flush;
  logic        flush_done;
  logic        empty;
  logic [3:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  write_buffer #(
    .DEPTH     (4),
    .BLK_OFF_W (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .st_valid      (st_valid),
    .st_addr       (st_addr),
    .st_data       (st_data),
    .st_ready      (st_ready),
    .mem_grant     (mem_grant),
    .mem_en        (mem_en),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .fill_addr     (fill_addr),
    .fill_conflict (fill_conflict),
    .flush         (flush),
    .flush_done    (flush_done),
    .empty         (empty),
    .count         (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1);
  end

  // Presents one store for the cycle that starts at this falling edge.
  task automatic push(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic idle();
    @(negedge clk);
    st_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
    mem_grant = 1'b0; fill_addr = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (st_ready !== 1'b1) begin n_errors++; $display("FAIL reset_st_ready: got %b want 1", st_ready); end
    n_checks++; if (mem_en !== 1'b0 || mem_wr !== 1'b0) begin n_errors++; $display("FAIL reset_mem_en: got en=%b wr=%b want 0", mem_en, mem_wr); end
    n_checks++; if (mem_addr !== 16'h0 || mem_data !== 16'h0) begin n_errors++; $display("FAIL reset_mem_bus: got %h/%h want 0", mem_addr, mem_data); end
    n_checks++; if (fill_conflict !== 1'b0 || flush_done !== 1'b0) begin n_errors++; $display("FAIL reset_flags: got fc=%b fd=%b want 0", fill_conflict, flush_done); end
    n_checks++; if (empty !== 1'b1 || count !== 4'd0) begin n_errors++; $display("FAIL reset_count: got empty=%b count=%0d want 1/0", empty, count); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_order();
    logic [15:0] exp_a [3];
    logic [15:0] exp_d [3];
    exp_a = '{16'h0010, 16'h0012, 16'h0100};
    exp_d = '{16'h1111, 16'h2222, 16'h3333};
    mem_grant = 1'b0;
    for (int i = 0; i < 3; i++) push(exp_a[i], exp_d[i]);
    idle();
    #1;
    n_checks++; if (count !== 4'd3) begin n_errors++; $display("FAIL order_count: got %0d want 3", count); end
    n_checks++; if (mem_en !== 1'b0) begin n_errors++; $display("FAIL order_no_grant: got mem_en=%b want 0", mem_en); end
    mem_grant = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      n_checks++;
      if (mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== exp_a[k] || mem_data !== exp_d[k]) begin
        n_errors++;
        $display("FAIL order_write%0d: got en=%b wr=%b %h=%h want 1 1 %h=%h",
                 k, mem_en, mem_wr, mem_addr, mem_data, exp_a[k], exp_d[k]);
      end
    end
    @(negedge clk); #1;
    n_checks++; if (empty !== 1'b1 || mem_en !== 1'b0) begin n_errors++; $display("FAIL order_empty: got empty=%b mem_en=%b want 1/0", empty, mem_en); end
    mem_grant = 1'b0;
  endtask

  task automatic test_full();
    logic [15:0] last;
    int writes;
    mem_grant = 1'b0;
    for (int i = 0; i < 4; i++) push(16'h0200 + 16'(2 * i), 16'h5000 + 16'(i));
    @(negedge clk);
    st_valid = 1'b1; st_addr = 16'h0300; st_data = 16'h5555;
    #1;
    n_checks++; if (st_ready !== 1'b0 || count !== 4'd4) begin n_errors++; $display("FAIL full_refuse: got ready=%b count=%0d want 0/4", st_ready, count); end
    @(negedge clk);
    mem_grant = 1'b1;
    #1;
    n_checks++; if (st_ready !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 16'h0200) begin n_errors++; $display("FAIL full_pop_cycle: got ready=%b en=%b addr=%h want 0 1 0200", st_ready, mem_en, mem_addr); end
    @(negedge clk); #1;
    n_checks++; if (st_ready !== 1'b1 || count !== 4'd3) begin n_errors++; $display("FAIL full_after_pop: got ready=%b count=%0d want 1/3", st_ready, count); end
    @(negedge clk);
    st_valid = 1'b0;
    #1;
    n_checks++; if (count !== 4'd3) begin n_errors++; $display("FAIL back_to_back_count: got %0d want 3", count); end
    last = '0; writes = 0;
    for (int c = 0; c < 12; c++) begin
      if (empty) break;
      if (mem_en) begin last = mem_data; writes++; end
      @(negedge clk); #1;
    end
    n_checks++; if (writes != 3 || last !== 16'h5555 || empty !== 1'b1) begin n_errors++; $display("FAIL full_drain: got writes=%0d last=%h empty=%b want 3 5555 1", writes, last, empty); end
    mem_grant = 1'b0;
  endtask

  task automatic test_conflict();
    mem_grant = 1'b0;
    push(16'h0014, 16'hC0DE);
    idle();
    fill_addr = 16'h001C;
    #1;
    n_checks++; if (fill_conflict !== 1'b1) begin n_errors++; $display("FAIL conflict_same_blk: got %b want 1", fill_conflict); end
    fill_addr = 16'h0020;
    #1;
    n_checks++; if (fill_conflict !== 1'b0) begin n_errors++; $display("FAIL conflict_other_blk: got %b want 0", fill_conflict); end
    mem_grant = 1'b1;
    @(negedge clk);
    mem_grant = 1'b0;
    fill_addr = 16'h001C;
    #1;
    n_checks++; if (fill_conflict !== 1'b0 || empty !== 1'b1) begin n_errors++; $display("FAIL conflict_after_drain: got fc=%b empty=%b want 0/1", fill_conflict, empty); end
    fill_addr = '0;
  endtask

  task automatic test_flush();
    logic g   [6];
    logic fd  [6];
    logic rdy [6];
    int pulses;
    g   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    fd  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    mem_grant = 1'b0;
    push(16'h0400, 16'h0001);
    push(16'h0402, 16'h0002);
    idle();
    flush = 1'b1;
    #1;
    n_checks++; if (flush_done !== 1'b0) begin n_errors++; $display("FAIL flush_start: got flush_done=%b want 0", flush_done); end
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      flush = 1'b0;
      mem_grant = g[k];
      #1;
      if (flush_done === 1'b1) pulses++;
      n_checks++;
      if (st_ready !== rdy[k] || flush_done !== fd[k]) begin
        n_errors++;
        $display("FAIL flush_cycle%0d: got ready=%b done=%b want %b %b", k, st_ready, flush_done, rdy[k], fd[k]);
      end
    end
    n_checks++; if (pulses != 1) begin n_errors++; $display("FAIL flush_pulses: got %0d want 1", pulses); end
    mem_grant = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    #1;
    n_checks++; if (flush_done !== 1'b0) begin n_errors++; $display("FAIL flush_empty_same: got %b want 0", flush_done); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_checks++; if (flush_done !== 1'b1) begin n_errors++; $display("FAIL flush_empty_next: got %b want 1", flush_done); end
    @(negedge clk); #1;
    n_checks++; if (flush_done !== 1'b0 || st_ready !== 1'b1) begin n_errors++; $display("FAIL flush_empty_after: got done=%b ready=%b want 0/1", flush_done, st_ready); end
  endtask

  task automatic test_reset_mid();
    int writes;
    mem_grant = 1'b0;
    push(16'h0500, 16'hA000);
    push(16'h0502, 16'hA001);
    push(16'h0504, 16'hA002);
    idle();
    mem_grant = 1'b1;
    #1;
    n_checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0500) begin n_errors++; $display("FAIL rstmid_first: got en=%b addr=%h want 1 0500", mem_en, mem_addr); end
    @(negedge clk); #1;
    n_checks++; if (mem_addr !== 16'h0502 || count !== 4'd2) begin n_errors++; $display("FAIL rstmid_second: got addr=%h count=%0d want 0502/2", mem_addr, count); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (count !== 4'd0 || mem_en !== 1'b0 || empty !== 1'b1 || mem_addr !== 16'h0) begin n_errors++; $display("FAIL rstmid_clear: got count=%0d en=%b empty=%b addr=%h want 0 0 1 0000", count, mem_en, empty, mem_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    writes = 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (mem_en !== 1'b0) writes++;
    end
    n_checks++; if (writes != 0) begin n_errors++; $display("FAIL rstmid_no_writes: got %0d want 0", writes); end
    mem_grant = 1'b0;
  endtask

  task automatic test_coalesce();
    logic [15:0] last;
    int writes;
    int exp_n;
`ifdef WB_COALESCE_EN
    exp_n = 1;
`else
    exp_n = 2;
`endif
    mem_grant = 1'b0;
    push(16'h0040, 16'hAAAA);
    push(16'h0040, 16'hBBBB);
    idle();
    #1;
    n_checks++; if (count !== 4'(exp_n)) begin n_errors++; $display("FAIL coalesce_count: got %0d want %0d", count, exp_n); end
    mem_grant = 1'b1;
    #1;
    last = '0; writes = 0;
    for (int c = 0; c < 12; c++) begin
      if (empty) break;
      if (mem_en) begin last = mem_data; writes++; end
      @(negedge clk); #1;
    end
    n_checks++; if (writes != exp_n || last !== 16'hBBBB || empty !== 1'b1) begin n_errors++; $display("FAIL coalesce_drain: got writes=%0d last=%h empty=%b want %0d BBBB 1", writes, last, empty, exp_n); end
    mem_grant = 1'b0;
  endtask

  initial begin
    test_reset();
    test_order();
    test_full();
    test_conflict();
    test_flush();
    test_reset_mid();
    test_coalesce();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
